// File: rtl/i2c_eeprom_target.sv
// i2c_eeprom_target: I2C target emulating a 24L0x-style serial EEPROM with a
// small on-chip byte memory. Handles two-address-byte writes (page writes
// wrap inside the memory), random reads, sequential reads and current-address
// reads. Every committed byte is also reported on wr_strobe/wr_addr/wr_data.
module i2c_eeprom_target #(
    parameter logic [6:0]  DEV_ADDR = 7'b1010001,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              scl,
    inout  wire               sda,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEV,
        S_AHI,
        S_ALO,
        S_WD,
        S_RD
    } state_t;

    // Synchronizer stages (m, s) plus one delayed copy (p) for edge detection
    logic scl_m_q, scl_s_q, scl_p_q;
    logic sda_m_q, sda_s_q, sda_p_q;

    logic start_ev, stop_ev, scl_rise, scl_fall;

    state_t            state_q,     state_d;
    logic [3:0]        bit_cnt_q,   bit_cnt_d;
    logic [6:0]        shift_q,     shift_d;
    logic [ADDR_W-1:0] ptr_q,       ptr_d;
    logic              sda_low_q,   sda_low_d;
    logic              busy_q,      busy_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [7:0]        wr_data_q,   wr_data_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem [DEPTH];

    logic [7:0]        rx_byte;
    logic [7:0]        rd_byte;

    // Two-flop synchronizers and the edge-detect copy; lines idle high
    always_ff @(posedge clk) begin
        if (!nrst) begin
            scl_m_q <= 1'b1;
            scl_s_q <= 1'b1;
            scl_p_q <= 1'b1;
            sda_m_q <= 1'b1;
            sda_s_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_m_q <= scl;
            scl_s_q <= scl_m_q;
            scl_p_q <= scl_s_q;
            sda_m_q <= sda;
            sda_s_q <= sda_m_q;
            sda_p_q <= sda_s_q;
        end
    end

    assign start_ev = scl_s_q &  sda_p_q & ~sda_s_q;
    assign stop_ev  = scl_s_q & ~sda_p_q &  sda_s_q;
    assign scl_rise =  scl_s_q & ~scl_p_q;
    assign scl_fall = ~scl_s_q &  scl_p_q;

    // Byte being shifted in, including the bit sampled on this rising edge
    assign rx_byte = {shift_q, sda_s_q};
    assign rd_byte = mem[ptr_q];

    // Byte memory: erased to 8'hFF on reset, one write port driven by the FSM
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '1;
            end
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Protocol state and datapath registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            sda_low_q   <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_low_q   <= sda_low_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Next-state logic. bit_cnt counts rising edges within a 9-bit slot;
    // bit_cnt==8 marks the acknowledge bit. The state advances only on the
    // rising edge of the ACK bit, so the ACK slot is owned by the byte's state.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_low_d   = sda_low_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = rx_byte;

        if (stop_ev) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (start_ev) begin
            state_d   = S_DEV;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                S_IDLE: begin
                end
                S_RD: begin
                    if (bit_cnt_q == 4'd8) begin
                        // Controller acknowledge: ACK continues, NACK ends the read
                        bit_cnt_d = '0;
                        ptr_d     = ptr_q + 1'b1;
                        if (sda_s_q) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        case (state_q)
                            S_DEV:   state_d = shift_q[0] ? S_RD : S_AHI;
                            S_AHI:   state_d = S_ALO;
                            S_ALO:   state_d = S_WD;
                            default: state_d = S_WD;
                        endcase
                    end else begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            case (state_q)
                                S_DEV: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        busy_d = 1'b1;
                                    end else begin
                                        state_d   = S_IDLE;
                                        bit_cnt_d = '0;
                                    end
                                end
                                S_ALO: begin
                                    ptr_d = rx_byte[ADDR_W-1:0];
                                end
                                S_WD: begin
                                    mem_we      = 1'b1;
                                    wr_strobe_d = 1'b1;
                                    wr_addr_d   = ptr_q;
                                    wr_data_d   = rx_byte;
                                    ptr_d       = ptr_q + 1'b1;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
            endcase
        end else if (scl_fall) begin
            if (state_q == S_RD && bit_cnt_q < 4'd8) begin
                sda_low_d = ~rd_byte[3'd7 - bit_cnt_q[2:0]];
            end else if ((state_q == S_DEV || state_q == S_AHI ||
                          state_q == S_ALO || state_q == S_WD) &&
                         bit_cnt_q == 4'd8) begin
                sda_low_d = 1'b1;
            end else begin
                sda_low_d = 1'b0;
            end
        end
    end

    assign sda       = sda_low_q ? 1'b0 : 1'bz;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Testbench for i2c_eeprom_target: bit-banged I2C controller, an array-based
// EEPROM reference model and a wr_strobe monitor.
module tb_i2c_eeprom_target;

    localparam logic [6:0] DEV = 7'h51;
    localparam int         Q   = 100;   // quarter SCL period in ns

    logic       clk     = 1'b0;
    logic       nrst    = 1'b0;
    logic       scl_r   = 1'b1;
    logic       drv_low = 1'b0;
    wire        sda;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    assign sda = drv_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_eeprom_target #(.DEV_ADDR(7'h51), .ADDR_W(4)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .scl       (scl_r),
        .sda       (sda),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // wr_strobe monitor
    int         strobe_cnt = 0;
    logic [3:0] s_addr_q[$];
    logic [7:0] s_data_q[$];

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            s_addr_q.push_back(wr_addr);
            s_data_q.push_back(wr_data);
        end
    end

    // Reference model
    logic [7:0] m_mem [16];
    logic [3:0] m_ptr;
    logic [7:0] exp_q[$];
    logic [3:0] exp_a_q[$];

    // Transaction buffers / observations
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int         nack_cnt;
    logic       busy_mid;
    logic       nack_line;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'hFF;
        m_ptr = 4'd0;
    endtask

    task automatic model_wr(input logic [7:0] alo);
        exp_a_q.delete();
        exp_q.delete();
        m_ptr = alo[3:0];
        foreach (txq[i]) begin
            m_mem[m_ptr] = txq[i];
            exp_a_q.push_back(m_ptr);
            exp_q.push_back(txq[i]);
            m_ptr = m_ptr + 4'd1;
        end
    endtask

    task automatic model_rd(input bit set_addr, input logic [7:0] alo, input int n);
        exp_q.delete();
        if (set_addr) m_ptr = alo[3:0];
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(m_mem[m_ptr]);
            m_ptr = m_ptr + 4'd1;
        end
    endtask

    // Bus primitives (all entered and left with SCL low, except start/stop)
    task automatic bit_out(input logic b, output logic seen);
        drv_low = ~b;
        #Q; scl_r = 1'b1;
        #Q; seen = sda;
        #Q; scl_r = 1'b0;
        #Q;
    endtask

    task automatic bit_in(output logic b);
        drv_low = 1'b0;
        #Q; scl_r = 1'b1;
        #Q; b = sda;
        #Q; scl_r = 1'b0;
        #Q;
    endtask

    task automatic gen_start();
        drv_low = 1'b0;
        #Q; scl_r = 1'b1;
        #Q; drv_low = 1'b1;
        #Q; scl_r = 1'b0;
        #Q;
    endtask

    task automatic gen_stop();
        drv_low = 1'b1;
        #Q; scl_r = 1'b1;
        #Q; drv_low = 1'b0;
        #Q; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack_seen);
        logic dummy;
        for (int i = 7; i >= 0; i--) bit_out(b[i], dummy);
        bit_in(ack_seen);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b, output logic line);
        logic [7:0] v;
        logic       bv;
        for (int i = 7; i >= 0; i--) begin
            bit_in(bv);
            v[i] = bv;
        end
        bit_out(nack, line);
        b = v;
    endtask

    task automatic wr_txn(input logic [7:0] ahi, input logic [7:0] alo);
        logic a;
        nack_cnt = 0;
        gen_start();
        send_byte({DEV, 1'b0}, a); if (a !== 1'b0) nack_cnt++;
        send_byte(ahi, a);         if (a !== 1'b0) nack_cnt++;
        send_byte(alo, a);         if (a !== 1'b0) nack_cnt++;
        foreach (txq[i]) begin
            send_byte(txq[i], a);  if (a !== 1'b0) nack_cnt++;
        end
        gen_stop();
    endtask

    task automatic rd_txn(input bit set_addr, input logic [7:0] alo, input int n);
        logic       a;
        logic [7:0] b;
        logic       line;
        nack_cnt = 0;
        rxq.delete();
        gen_start();
        if (set_addr) begin
            send_byte({DEV, 1'b0}, a); if (a !== 1'b0) nack_cnt++;
            send_byte(8'h00, a);       if (a !== 1'b0) nack_cnt++;
            send_byte(alo, a);         if (a !== 1'b0) nack_cnt++;
            gen_start();
        end
        send_byte({DEV, 1'b1}, a); if (a !== 1'b0) nack_cnt++;
        for (int k = 0; k < n; k++) begin
            recv_byte(k == n - 1, b, line);
            rxq.push_back(b);
            nack_line = line;
        end
        busy_mid = busy;
        gen_stop();
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        repeat (5) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (sda !== 1'b1)      begin n_fail++; $display("FAIL reset_sda got %b exp 1", sda); end
        n_checks++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe got %b exp 0", wr_strobe); end
        n_checks++; if (wr_addr !== 4'h0)  begin n_fail++; $display("FAIL reset_wr_addr got %h exp 0", wr_addr); end
        n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got %h exp 00", wr_data); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    endtask

    task automatic check_strobes(input string name, input int base);
        n_checks++;
        if (strobe_cnt - base != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_strobe_count got %0d exp %0d", name, strobe_cnt - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [3:0] ga;
            logic [7:0] gd;
            ga = (i < s_addr_q.size()) ? s_addr_q[i] : 4'hx;
            gd = (i < s_data_q.size()) ? s_data_q[i] : 8'hxx;
            n_checks++;
            if (ga !== exp_a_q[i] || gd !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_strobe%0d got %h/%h exp %h/%h", name, i, ga, gd, exp_a_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic check_read(input string name);
        n_checks++;
        if (rxq.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_len got %0d exp %0d", name, rxq.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rxq.size(); i++) begin
            n_checks++;
            if (rxq[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s_byte%0d got %h exp %h", name, i, rxq[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_write_basic();
        int base;
        base = strobe_cnt;
        s_addr_q.delete(); s_data_q.delete();
        txq = '{8'h5A};
        wr_txn(8'h00, 8'h03);
        model_wr(8'h03);
        n_checks++; if (nack_cnt != 0) begin n_fail++; $display("FAIL write_acks got %0d nacks exp 0", nack_cnt); end
        check_strobes("write", base);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop got %b exp 0", busy); end
    endtask

    task automatic test_random_read();
        rd_txn(1'b1, 8'h03, 1);
        model_rd(1'b1, 8'h03, 1);
        n_checks++; if (nack_cnt != 0) begin n_fail++; $display("FAIL rread_acks got %0d nacks exp 0", nack_cnt); end
        check_read("rread");
        n_checks++; if (rxq.size() < 1 || rxq[0] !== 8'h5A) begin n_fail++; $display("FAIL rread_value got %h exp 5a", rxq.size() ? rxq[0] : 8'hxx); end
        n_checks++; if (nack_line !== 1'b1) begin n_fail++; $display("FAIL rread_nack_released got %b exp 1", nack_line); end
        n_checks++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL rread_busy_mid got %b exp 1", busy_mid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rread_busy_after_stop got %b exp 0", busy); end
    endtask

    task automatic test_bad_addr();
        logic a;
        int   base;
        base = strobe_cnt;
        gen_start();
        send_byte({7'h50, 1'b0}, a);
        n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL badaddr_ack got %b exp 1", a); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badaddr_busy got %b exp 0", busy); end
        send_byte(8'h00, a);
        send_byte(8'h03, a);
        send_byte(8'h11, a);
        gen_stop();
        n_checks++; if (strobe_cnt != base) begin n_fail++; $display("FAIL badaddr_strobes got %0d exp %0d", strobe_cnt, base); end
        rd_txn(1'b1, 8'h03, 1);
        model_rd(1'b1, 8'h03, 1);
        check_read("badaddr_mem");
    endtask

    task automatic test_page_wrap();
        int base;
        base = strobe_cnt;
        s_addr_q.delete(); s_data_q.delete();
        txq = '{8'hA0, 8'hA1, 8'hA2};
        wr_txn(8'h00, 8'h0F);
        model_wr(8'h0F);
        n_checks++; if (nack_cnt != 0) begin n_fail++; $display("FAIL page_acks got %0d nacks exp 0", nack_cnt); end
        check_strobes("page", base);
    endtask

    task automatic test_seq_read();
        rd_txn(1'b1, 8'h0E, 3);
        model_rd(1'b1, 8'h0E, 3);
        check_read("seqread");
        // current-address read shows where the pointer was left
        rd_txn(1'b0, 8'h00, 1);
        model_rd(1'b0, 8'h00, 1);
        n_checks++; if (nack_cnt != 0) begin n_fail++; $display("FAIL curread_acks got %0d nacks exp 0", nack_cnt); end
        check_read("curread");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] alo, ahi, ralo;
            int         len, rlen, base;
            alo  = 8'($urandom);
            ahi  = 8'($urandom);
            len  = $urandom_range(1, 4);
            txq.delete();
            for (int k = 0; k < len; k++) txq.push_back(8'($urandom));
            base = strobe_cnt;
            s_addr_q.delete(); s_data_q.delete();
            wr_txn(ahi, alo);
            model_wr(alo);
            n_checks++; if (nack_cnt != 0) begin n_fail++; $display("FAIL rand%0d_wr_acks got %0d nacks exp 0", it, nack_cnt); end
            check_strobes("rand_wr", base);
            ralo = 8'($urandom);
            rlen = $urandom_range(1, 5);
            rd_txn(1'b1, ralo, rlen);
            model_rd(1'b1, ralo, rlen);
            check_read("rand_rd");
        end
    endtask

    task automatic test_reset_mid();
        logic a, b;
        int   base;
        logic [7:0] d;
        // Reset while the target is driving a 0 data bit
        txq = '{8'h00};
        wr_txn(8'h00, 8'h07);
        model_wr(8'h07);
        gen_start();
        send_byte({DEV, 1'b0}, a);
        send_byte(8'h00, a);
        send_byte(8'h07, a);
        gen_start();
        send_byte({DEV, 1'b1}, a);
        for (int i = 0; i < 4; i++) bit_in(b);
        drv_low = 1'b0;
        #Q; scl_r = 1'b1;
        #Q;
        n_checks++; if (sda !== 1'b0) begin n_fail++; $display("FAIL rstmid_drive_before got %b exp 0", sda); end
        nrst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rstmid_rd_release got %b exp 1", sda); end
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        model_reset();

        // Reset during the 5th bit of a write data byte
        base = strobe_cnt;
        d = 8'hC3;
        gen_start();
        send_byte({DEV, 1'b0}, a);
        send_byte(8'h00, a);
        send_byte(8'h09, a);
        for (int i = 7; i > 3; i--) bit_out(d[i], b);
        drv_low = ~d[3];
        #Q; scl_r = 1'b1;
        #Q;
        nrst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (sda !== 1'b0 && drv_low) begin n_fail++; $display("FAIL rstmid_wr_line got %b exp 0", sda); end
        repeat (3) @(negedge clk);
        drv_low = 1'b0;
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        model_reset();
        n_checks++; if (strobe_cnt != base) begin n_fail++; $display("FAIL rstmid_commit got %0d strobes exp %0d", strobe_cnt, base); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy); end

        // Memory erased
        rd_txn(1'b1, 8'h00, 16);
        model_rd(1'b1, 8'h00, 16);
        check_read("rstmid_erased");

        // Full transaction afterwards
        base = strobe_cnt;
        s_addr_q.delete(); s_data_q.delete();
        txq = '{8'h3C};
        wr_txn(8'h00, 8'h02);
        model_wr(8'h02);
        n_checks++; if (nack_cnt != 0) begin n_fail++; $display("FAIL rstmid_after_acks got %0d nacks exp 0", nack_cnt); end
        check_strobes("rstmid_after", base);
        rd_txn(1'b1, 8'h02, 1);
        model_rd(1'b1, 8'h02, 1);
        check_read("rstmid_after_rd");
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_random_read();
        test_bad_addr();
        test_page_wrap();
        test_seq_read();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
